// File: rtl/anc_sample_aligner_if.sv
// Sample-stream and aligned-frame bundle for anc_sample_aligner.
// The master side produces the three strobed sample streams and the downstream
// ready. The slave side (the aligner) returns the aligned frame.
interface anc_sample_aligner_if #(
  parameter int DW = 16
);
  logic          e_stb;
  logic [DW-1:0] e_smp;
  logic          x_stb;
  logic [DW-1:0] x_smp;
  logic          a_stb;
  logic [DW-1:0] a_smp;
  logic          ctrl_ready;
  logic          frame_valid;
  logic [DW-1:0] e_out;
  logic [DW-1:0] x_out;
  logic [DW-1:0] a_out;

  modport master (
    output e_stb, e_smp, x_stb, x_smp, a_stb, a_smp, ctrl_ready,
    input  frame_valid, e_out, x_out, a_out
  );

  modport slave (
    input  e_stb, e_smp, x_stb, x_smp, a_stb, a_smp, ctrl_ready,
    output frame_valid, e_out, x_out, a_out
  );
endinterface

// File: rtl/anc_sample_aligner.sv
// Collects one sample from each of the error, reference and desired channels
// into a frame. Complete frames are queued in a small FIFO that feeds the
// controller through a valid/ready handshake. Overruns and dropped frames are
// reported through sticky flags and a saturating counter.
module anc_sample_aligner #(
  parameter int DW    = 16,
  parameter int DEPTH = 2      // 2 or 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr_err,
  anc_sample_aligner_if.slave    bus,
  output logic [2:0]             ovr_err,
  output logic [7:0]             drop_cnt,
  output logic [2:0]             fifo_level
);
  // Pointer width. DEPTH is a power of two, so natural overflow of the
  // pointers gives the modulo-DEPTH wrap.
  localparam int PW = (DEPTH > 2) ? 2 : 1;

  logic [2:0]      stb;
  logic [DW-1:0]   smp [3];
  logic [DW-1:0]   cap_reg [3];
  logic [2:0]      mask_reg, mask_next, avail, load, ovr_evt;
  logic [2:0]      ovr_reg, ovr_next;
  logic [7:0]      drop_reg, drop_next;
  logic [2:0]      level_reg, level_next;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [3*DW-1:0] mem [DEPTH];
  logic [3*DW-1:0] head;
  logic            push_req, pop, full, do_write, do_drop, frame_valid;

  // Channel index 0 = e, 1 = x, 2 = a. This matches the ovr_err bit order.
  assign stb    = {bus.a_stb, bus.x_stb, bus.e_stb};
  assign smp[0] = bus.e_smp;
  assign smp[1] = bus.x_smp;
  assign smp[2] = bus.a_smp;

  assign push_req    = (mask_reg == 3'b111);
  assign frame_valid = (level_reg != 3'd0);
  assign full        = (level_reg == 3'(DEPTH));
  assign pop         = frame_valid && bus.ctrl_ready;
  assign do_write    = push_req && (!full || pop);
  assign do_drop     = push_req && full && !pop;

  // Decide per channel whether a strobe captures or overruns. On a push edge
  // the frame slot is already free, so those strobes start the next frame.
  always_comb begin
    avail     = push_req ? 3'b000 : mask_reg;
    load      = 3'b000;
    ovr_evt   = 3'b000;
    mask_next = 3'b000;
    if (en) begin
      load      = stb & ~avail;
      ovr_evt   = stb & avail;
      mask_next = avail | stb;
    end
  end

  // Error bookkeeping: clear first, so an event on the same edge still lands.
  always_comb begin
    ovr_next  = (clr_err ? 3'b000 : ovr_reg) | ovr_evt;
    drop_next = clr_err ? 8'd0 : drop_reg;
    if (do_drop && drop_next != 8'hFF) begin
      drop_next = drop_next + 8'd1;
    end
    level_next = level_reg + {2'b00, do_write} - {2'b00, pop};
  end

  // Per-channel capture registers. A sample is loaded only into a free slot.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cap
      always_ff @(posedge clk) begin
        if (rst) begin
          cap_reg[gi] <= '0;
        end else if (load[gi]) begin
          cap_reg[gi] <= smp[gi];
        end
      end
    end
  endgenerate

  // Mask, error, occupancy and pointer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg   <= 3'b000;
      ovr_reg    <= 3'b000;
      drop_reg   <= 8'd0;
      level_reg  <= 3'd0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      mask_reg  <= mask_next;
      ovr_reg   <= ovr_next;
      drop_reg  <= drop_next;
      level_reg <= level_next;
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Frame storage. This needs no reset because the outputs are gated by
  // occupancy.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= {cap_reg[2], cap_reg[1], cap_reg[0]};
    end
  end

  assign head            = mem[rd_ptr_reg];
  assign bus.frame_valid = frame_valid;
  assign bus.e_out       = frame_valid ? head[DW-1:0]      : '0;
  assign bus.x_out       = frame_valid ? head[2*DW-1:DW]   : '0;
  assign bus.a_out       = frame_valid ? head[3*DW-1:2*DW] : '0;
  assign ovr_err         = ovr_reg;
  assign drop_cnt        = drop_reg;
  assign fifo_level      = level_reg;
endmodule
